// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and constants for the switch output arbiter
package switch_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int NUM_OUT         = 4;
    localparam int DEST_W          = 2;
    localparam int SEL_W           = 3;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/switch_arbiter_rr_pick.sv
// rtl/switch_arbiter_rr_pick.sv - combinational round-robin selector starting at ptr
module rr_pick
    import switch_pkg::*;
#(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    localparam logic [SEL_W:0] N_W = (SEL_W+1)'(NUM_IN);

    logic [2*NUM_IN-1:0] req_dbl;
    logic [NUM_IN-1:0]   rot;
    logic [SEL_W:0]      sum;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign req_dbl = {req, req};
    assign rot     = NUM_IN'(req_dbl >> ptr);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (SEL_W+1)'(k);
                idx   = (sum >= N_W) ? SEL_W'(sum - N_W) : SEL_W'(sum);
            end
        end
    end

endmodule

// File: rtl/switch_arbiter.sv
// rtl/switch_arbiter.sv - per-output round-robin packet arbiter for the switch output FIFOs
module switch_arbiter
    import switch_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        req,
    input  logic [DEST_W*NUM_IN-1:0] req_dest,
    input  logic [NUM_IN-1:0]        eop,
    input  logic [NUM_OUT-1:0]       ffee,
    output logic [NUM_IN-1:0]        gnt,
    output logic [SEL_W*NUM_OUT-1:0] out_sel,
    output logic [NUM_OUT-1:0]       out_busy,
    output logic [NUM_OUT-1:0]       timeout_err
);

    localparam int              WD_W   = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    arb_state_t       state_q [NUM_OUT];
    arb_state_t       state_d [NUM_OUT];
    logic [SEL_W-1:0] sel_q   [NUM_OUT];
    logic [SEL_W-1:0] sel_d   [NUM_OUT];
    logic [SEL_W-1:0] ptr_q   [NUM_OUT];
    logic [SEL_W-1:0] ptr_d   [NUM_OUT];
    logic [WD_W-1:0]  wd_q    [NUM_OUT];
    logic [WD_W-1:0]  wd_d    [NUM_OUT];

    logic [NUM_IN-1:0]  cand     [NUM_OUT];
    logic [SEL_W-1:0]   pick_idx [NUM_OUT];
    logic [NUM_OUT-1:0] found;
    logic [NUM_OUT-1:0] own_eop;
    logic [NUM_OUT-1:0] own_req;
    logic [NUM_OUT-1:0] wd_done;

    // Inputs already holding a grant are excluded so an input never owns two outputs.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cand[o][i] = req[i] && !gnt[i] &&
                             (req_dest[DEST_W*i +: DEST_W] == DEST_W'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_pick
        rr_pick #(.NUM_IN(NUM_IN)) u_pick (
            .req   (cand[o]),
            .ptr   (ptr_q[o]),
            .found (found[o]),
            .idx   (pick_idx[o])
        );
    end

    always_comb begin
        own_eop = '0;
        own_req = '0;
        wd_done = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel_q[o] == SEL_W'(i)) begin
                    own_eop[o] = eop[i];
                    own_req[o] = req[i];
                end
            end
            wd_done[o] = (wd_q[o] == WD_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= ARB_IDLE;
                sel_q[o]   <= '0;
                ptr_q[o]   <= '0;
                wd_q[o]    <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                state_q[o] <= state_d[o];
                sel_q[o]   <= sel_d[o];
                ptr_q[o]   <= ptr_d[o];
                wd_q[o]    <= wd_d[o];
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            state_d[o] = state_q[o];
            sel_d[o]   = sel_q[o];
            ptr_d[o]   = ptr_q[o];
            wd_d[o]    = wd_q[o];
            case (state_q[o])
                ARB_IDLE: begin
                    if (found[o] && ffee[o]) begin
                        state_d[o] = ARB_LOCKED;
                        sel_d[o]   = pick_idx[o];
                        ptr_d[o]   = (pick_idx[o] == SEL_W'(NUM_IN - 1)) ? '0
                                     : pick_idx[o] + SEL_W'(1);
                        wd_d[o]    = '0;
                    end
                end
                ARB_LOCKED: begin
                    // out_sel holds its last value after release; only the state drops.
                    if (own_eop[o] || !own_req[o] || wd_done[o]) begin
                        state_d[o] = ARB_IDLE;
                    end else begin
                        wd_d[o] = wd_q[o] + WD_W'(1);
                    end
                end
                default: state_d[o] = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt         = '0;
        out_sel     = '0;
        out_busy    = '0;
        timeout_err = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            out_sel[SEL_W*o +: SEL_W] = sel_q[o];
            out_busy[o]               = (state_q[o] == ARB_LOCKED);
            // A pending reset suppresses the pulse: that release is not a timeout.
            timeout_err[o] = !reset && out_busy[o] && wd_done[o] &&
                             own_req[o] && !own_eop[o];
            for (int i = 0; i < NUM_IN; i++) begin
                if (out_busy[o] && sel_q[o] == SEL_W'(i)) begin
                    gnt[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_arbiter.sv
// tb/tb_switch_arbiter.sv - directed self-checking bench for switch_arbiter
module tb_switch_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_dest;
    logic [3:0]  eop;
    logic [3:0]  ffee;
    logic [3:0]  gnt;
    logic [11:0] out_sel;
    logic [3:0]  out_busy;
    logic [3:0]  timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    switch_arbiter #(.NUM_IN(4), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_dest    (req_dest),
        .eop         (eop),
        .ffee        (ffee),
        .gnt         (gnt),
        .out_sel     (out_sel),
        .out_busy    (out_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int order [4] = '{0, 1, 3, 0};

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_dest = '0;
        eop      = '0;
        ffee     = 4'b1111;
        step();
        step();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(out_busy), 0);
        check("rst_sel", 32'(out_sel), 0);
        check("rst_terr", 32'(timeout_err), 0);
        reset = 1'b0;

        // single request to output 2
        req      = 4'b0001;
        req_dest = 8'h02;
        step();
        check("single_gnt", 32'(gnt), 1);
        check("single_sel2", 32'(out_sel[8:6]), 0);
        check("single_busy", 32'(out_busy), 'h4);
        eop = 4'b0001;
        step();
        eop = '0;
        req = '0;
        check("single_rel_gnt", 32'(gnt), 0);
        check("single_rel_busy", 32'(out_busy), 0);

        // contention on output 1 from inputs 0, 1, 3
        req      = 4'b1011;
        req_dest = 8'h45;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_gnt", 32'(gnt), 32'(1 << order[k]));
            check("rr_sel", 32'(out_sel[5:3]), 32'(order[k]));
            step();
            step();
            step();
            check("rr_hold", 32'(gnt), 32'(1 << order[k]));
            eop = 4'(1 << order[k]);
            step();
            eop = '0;
            if (k == 3) req = '0;
            check("rr_bubble_gnt", 32'(gnt), 0);
            check("rr_bubble_busy", 32'(out_busy[1]), 0);
        end
        step();
        check("rr_done", 32'(gnt), 0);

        // full FIFO holds off the grant
        req      = 4'b0100;
        req_dest = 8'h30;
        ffee     = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            step();
            check("full_nogrant", 32'(gnt), 0);
        end
        ffee = 4'b1111;
        step();
        check("full_gnt", 32'(gnt), 'h4);
        check("full_sel3", 32'(out_sel[11:9]), 2);
        req = '0;
        step();
        check("full_abort", 32'(out_busy), 0);

        // parallel independent outputs
        req      = 4'b1111;
        req_dest = 8'hE4;
        step();
        check("par_gnt", 32'(gnt), 'hF);
        check("par_sel", 32'(out_sel), 'h688);
        check("par_busy", 32'(out_busy), 'hF);
        req = '0;
        step();
        check("par_rel", 32'(gnt), 0);

        // watchdog with TIMEOUT=8
        req      = 4'b0010;
        req_dest = 8'h00;
        step();
        check("wd_gnt", 32'(gnt), 'h2);
        for (int c = 2; c <= 8; c++) begin
            step();
            check("wd_terr", 32'(timeout_err), (c == 8) ? 1 : 0);
        end
        step();
        req = '0;
        check("wd_rel_gnt", 32'(gnt), 0);
        check("wd_rel_terr", 32'(timeout_err), 0);

        // abort on 3rd locked cycle
        req = 4'b0010;
        step();
        check("ab_gnt", 32'(gnt), 'h2);
        step();
        step();
        req = '0;
        #1;
        check("ab_terr_c3", 32'(timeout_err), 0);
        step();
        check("ab_rel_gnt", 32'(gnt), 0);
        check("ab_rel_busy", 32'(out_busy), 0);
        for (int c = 0; c < 8; c++) begin
            step();
            check("ab_no_terr", 32'(timeout_err), 0);
        end

        // reset mid-packet with three outputs locked, on the would-be timeout cycle
        req      = 4'b0111;
        req_dest = 8'h24;
        step();
        check("rm_gnt", 32'(gnt), 'h7);
        for (int c = 0; c < 7; c++) step();
        reset = 1'b1;
        #1;
        check("rm_terr_during", 32'(timeout_err), 0);
        step();
        reset = 1'b0;
        check("rm_gnt_after", 32'(gnt), 0);
        check("rm_busy_after", 32'(out_busy), 0);
        check("rm_sel_after", 32'(out_sel), 0);
        check("rm_terr_after", 32'(timeout_err), 0);
        req      = 4'b1010;
        req_dest = 8'h44;
        step();
        check("rm_ptr_gnt", 32'(gnt), 'h2);
        check("rm_ptr_sel", 32'(out_sel[5:3]), 1);
        req = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_arbiter.md
Name: switch_arbiter

Overview:
- Shares the four switch output FIFOs between NUM_IN input-port controllers.
- Each input port raises a request carrying the destination index decoded from its address byte.
- The arbiter grants each output FIFO to at most one input at a time, round-robin. Each grant is held for a whole packet, until end-of-packet, abort or watchdog timeout.
- Sits between the input-port FSMs and the output FIFO write-mux; drives the mux selects and per-input grants.

Parameters:
- NUM_IN, 4, number of requesting input ports (2..8).
- NUM_OUT, 4, number of output FIFOs (fixed 4, matching the four address registers).
- TIMEOUT, 64, cycles a locked output may go without eop before forced release (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_IN  req[i]=1: input i has a packet pending or in flight.
- req_dest  in  2*NUM_IN  bits [2i+1:2i] = destination output index of input i; valid while req[i]=1.
- eop  in  NUM_IN  eop[i]=1: input i wrote its parity byte this cycle.
- ffee  in  NUM_OUT  ffee[o]=1: output FIFO o has room for a new packet.
- gnt  out  NUM_IN  gnt[i]=1: input i owns its requested output FIFO.
- out_sel  out  3*NUM_OUT  bits [3o+2:3o] = index of the input driving output o.
- out_busy  out  NUM_OUT  out_busy[o]=1: output o is locked to an owner.
- timeout_err  out  NUM_OUT  one-cycle pulse when output o is force-released.

Behaviour:
- Reset, sampled at the clk edge: gnt=0, out_sel=0, out_busy=0, timeout_err=0, all RR pointers=0, watchdog counters=0, all output FSMs in IDLE.

Per-output FSM, 2 states:
- IDLE: candidates = {i : req[i]=1, req_dest[i]=o, gnt[i]=0}.
  - If at least one candidate and ffee[o]=1, pick the first candidate in round-robin order, starting at pointer[o].
  - Next cycle: LOCKED, out_sel[o]=winner, gnt[winner]=1, out_busy[o]=1, pointer[o]=(winner+1) mod NUM_IN, watchdog=0.
  - If ffee[o]=0, no grant is made; stay IDLE.
- LOCKED: release to IDLE when any of the following is true of the owner:
  - eop[owner]=1 (normal end of packet);
  - req[owner]=0 (abort);
  - watchdog reaches TIMEOUT-1. This also pulses timeout_err[o] for that one cycle.
  - On release: gnt[owner]=0, out_busy[o]=0 on the next cycle.
  - out_sel[o] keeps its last value.
  - Otherwise the watchdog increments each cycle.
  - ffee[o] has no effect while LOCKED; mid-packet backpressure is the input FSM's hold path.
- Latency: req to gnt is 1 cycle. Release to earliest new grant on the same output is 2 cycles: one IDLE bubble, mandatory.
- Simultaneous eop and req from the same input in the release cycle: that input is not eligible for the grant decision in that cycle.
  - It becomes eligible when the output is back in IDLE.
  - Its priority is already lowest because the pointer has advanced.
- req_dest changing while gnt[i]=1 is illegal. The arbiter ignores it; ownership follows the latched out_sel.
- An input can hold at most one grant. gnt[i] is the OR over outputs of (LOCKED and out_sel=i).
- eop[i] with gnt[i]=0 is ignored.
- Independent outputs grant in the same cycle without interaction.
- Reset asserted mid-packet: all grants drop on the next edge; no timeout_err is generated.
- Arithmetic:
  - The watchdog width is clog2(TIMEOUT); it never wraps, because release occurs at TIMEOUT-1.
  - Pointer arithmetic is mod NUM_IN.

Decomposition:
- Package switch_pkg:
  - State encoding: ARB_IDLE=1'b0, ARB_LOCKED=1'b1.
  - Constants NUM_OUT=4, DEST_W=2, SEL_W=3.
  - Default TIMEOUT.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: NUM_IN request vector and pointer.
  - Outputs: found flag and winner index.
  - Instantiated once per output.
- FSMs, watchdogs and pointer registers live in switch_arbiter.

Test Plan:
- Single request: req=0001, req_dest[0]=2, ffee=1111.
  - Response: gnt[0]=1 one cycle later, out_sel[2]=0, out_busy=0100.
  - eop[0] pulse: gnt=0 and out_busy=0000 the next cycle.
- Contention and fairness: inputs 0, 1 and 3 all request output 1 continuously, each packet 4 cycles with eop on its last cycle.
  - Grant order: 0, 1, 3, 0.
  - Exactly one IDLE cycle between each release and the next grant.
- Full FIFO: req[2]=1, req_dest[2]=3, ffee[3]=0 for 10 cycles, then ffee[3]=1.
  - No grant while ffee[3]=0.
  - gnt[2]=1 one cycle after ffee[3] rises.
- Parallel outputs: inputs 0→0, 1→1, 2→2, 3→3 requested in the same cycle.
  - All four gnt bits asserted in the same cycle.
  - out_sel = {3,2,1,0}.
- Watchdog: TIMEOUT=8, input 1 granted output 0, never sends eop.
  - timeout_err[0] pulses on the 8th LOCKED cycle.
  - gnt[1] drops the following cycle.
  - Abort variant: req[1] drops on the 3rd LOCKED cycle; release occurs with no timeout_err.
- Reset mid-packet: reset=1 for one cycle while 3 outputs are locked.
  - Next cycle: gnt=0, out_busy=0, pointers=0, timeout_err=0.
  - A new request afterwards is granted starting from input 0's priority.
